// File: rtl/uart_receiver_if.sv
// rtl/uart_receiver_if.sv - serial line and received-data bundle for uart_receiver
//
// Purpose: groups the baud enable, serial input and receive results so that the
// receiver and its users share one port.
// Signals:
//   i_baud        oversampling enable, one clock wide
//   i_rx          serial line, idle high
//   o_data        last correctly received word
//   o_rx_done     one-cycle pulse, o_data updated
//   o_frame_error one-cycle pulse, stop bit sampled low
// Modports: master drives the line side, slave is the receiver.

interface uart_receiver_if #(
  parameter int NDATA_BITS = 8
);
  logic                  i_baud;
  logic                  i_rx;
  logic [NDATA_BITS-1:0] o_data;
  logic                  o_rx_done;
  logic                  o_frame_error;

  modport master (
    output i_baud,
    output i_rx,
    input  o_data,
    input  o_rx_done,
    input  o_frame_error
  );

  modport slave (
    input  i_baud,
    input  i_rx,
    output o_data,
    output o_rx_done,
    output o_frame_error
  );
endinterface

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - oversampling UART receiver with glitch and frame error detection
//
// Purpose: receives LSB-first frames (start, NDATA_BITS data, NSTOP_BITS stop) from
// an idle-high serial line. Bits are sampled once per bit period, on the
// OVERSAMPLING-th i_baud tick counted from the middle of the start bit.
// Ports:
//   i_clock  system clock, rising edge
//   i_reset  synchronous, active-high reset
//   bus      uart_receiver_if.slave (i_baud, i_rx, o_data, o_rx_done, o_frame_error)
// Build option: UART_RX_SYNC_EN adds a two-flop synchronizer on i_rx.

module uart_receiver #(
  parameter int NDATA_BITS   = 8,
  parameter int NSTOP_BITS   = 1,
  parameter int OVERSAMPLING = 16
) (
  input  logic            i_clock,
  input  logic            i_reset,
  uart_receiver_if.slave  bus
);

  localparam int TICK_W = $clog2(OVERSAMPLING);
  localparam int BIT_W  = (NDATA_BITS > 1) ? $clog2(NDATA_BITS) : 1;
  localparam int STOP_W = (NSTOP_BITS > 1) ? $clog2(NSTOP_BITS) : 1;

  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLING / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLING - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(NDATA_BITS - 1);
  localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(NSTOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic rx_s;
  logic baud_s;

`ifdef UART_RX_SYNC_EN
  // The baud enable is delayed alongside the line so that the sample points keep
  // the same phase within each bit; everything then lands exactly two cycles later.
  logic [1:0] rx_sync;
  logic [1:0] baud_sync;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rx_sync   <= 2'b11;
      baud_sync <= 2'b00;
    end else begin
      rx_sync   <= {rx_sync[0], bus.i_rx};
      baud_sync <= {baud_sync[0], bus.i_baud};
    end
  end

  assign rx_s   = rx_sync[1];
  assign baud_s = baud_sync[1];
`else
  assign rx_s   = bus.i_rx;
  assign baud_s = bus.i_baud;
`endif

  state_t                state;
  logic [TICK_W-1:0]     tick;
  logic [BIT_W-1:0]      bit_idx;
  logic [STOP_W-1:0]     stop_idx;
  logic [NDATA_BITS-1:0] shift_reg;
  logic [NDATA_BITS-1:0] data_q;
  logic                  rx_prev;
  logic                  rx_done_q;
  logic                  frame_error_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= IDLE;
      tick          <= '0;
      bit_idx       <= '0;
      stop_idx      <= '0;
      shift_reg     <= '0;
      data_q        <= '0;
      rx_prev       <= 1'b1;
      rx_done_q     <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      // Tracked every cycle, so a break after a frame error needs a rising
      // edge before the next falling edge can start a frame.
      rx_prev       <= rx_s;
      rx_done_q     <= 1'b0;
      frame_error_q <= 1'b0;

      case (state)
        IDLE: begin
          if (rx_prev && !rx_s) begin
            state <= START;
            tick  <= '0;
          end
        end

        START: begin
          if (baud_s) begin
            if (tick == TICK_MID) begin
              tick    <= '0;
              bit_idx <= '0;
              // A line back high at mid start bit was a glitch.
              state   <= rx_s ? IDLE : DATA;
            end else begin
              tick <= tick + 1'b1;
            end
          end
        end

        DATA: begin
          if (baud_s) begin
            if (tick == TICK_LAST) begin
              tick      <= '0;
              shift_reg <= NDATA_BITS'({rx_s, shift_reg} >> 1);
              if (bit_idx == BIT_LAST) begin
                state    <= STOP;
                stop_idx <= '0;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end else begin
              tick <= tick + 1'b1;
            end
          end
        end

        STOP: begin
          if (baud_s) begin
            if (tick == TICK_LAST) begin
              tick <= '0;
              if (!rx_s) begin
                frame_error_q <= 1'b1;
                state         <= IDLE;
              end else if (stop_idx == STOP_LAST) begin
                data_q    <= shift_reg;
                rx_done_q <= 1'b1;
                state     <= IDLE;
              end else begin
                stop_idx <= stop_idx + 1'b1;
              end
            end else begin
              tick <= tick + 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_data        = data_q;
  assign bus.o_rx_done     = rx_done_q;
  assign bus.o_frame_error = frame_error_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - scoreboard testbench for uart_receiver

module tb_uart_receiver;

  localparam int NDATA_BITS = 8;
  localparam int BIT_CLKS   = 64;
`ifdef UART_RX_SYNC_EN
  localparam int LATENCY = 610;
`else
  localparam int LATENCY = 608;
`endif

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   bc;
  int   tests;
  int   fails;
  exp_t sb[$];

  uart_receiver_if #(.NDATA_BITS(NDATA_BITS)) bus ();

  uart_receiver #(
    .NDATA_BITS  (NDATA_BITS),
    .NSTOP_BITS  (1),
    .OVERSAMPLING(16)
  ) dut (
    .i_clock(clk),
    .i_reset(reset),
    .bus    (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus: i_baud is high on every fourth clock.
  task automatic step(input logic rx);
    @(negedge clk);
    bc = (bc + 1) % 4;
    bus.i_baud = (bc == 0);
    bus.i_rx   = rx;
  endtask

  task automatic hold(input logic rx, input int n);
    for (int i = 0; i < n; i++) step(rx);
  endtask

  // Line idles until the start bit coincides with a baud tick, fixing the
  // sample phase so the stop-bit sample lands LATENCY clocks after the edge.
  task automatic align();
    while (bc != 3) step(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input bit expect_err,
                            input logic [7:0] exp_data);
    exp_t e;
    align();
    step(1'b0);
    e.is_err = expect_err;
    e.data   = exp_data;
    e.cyc    = cyc + 1 + LATENCY;
    sb.push_back(e);
    hold(1'b0, BIT_CLKS - 1);
    for (int b = 0; b < 8; b++) hold(d[b], BIT_CLKS);
    hold(stop, BIT_CLKS);
  endtask

  // Monitor: every output pulse is matched against the head of the scoreboard.
  initial begin
    logic prev_done;
    logic prev_err;
    exp_t e;
    prev_done = 1'b0;
    prev_err  = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.o_rx_done || bus.o_frame_error) begin
        check("pulses_exclusive", {31'd0, bus.o_rx_done & bus.o_frame_error}, 32'd0);
        check("pulse_one_cycle", {31'd0, (bus.o_rx_done & prev_done) | (bus.o_frame_error & prev_err)}, 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_pulse", {30'd0, bus.o_frame_error, bus.o_rx_done}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("pulse_kind_err", {31'd0, bus.o_frame_error}, {31'd0, e.is_err});
          check("o_data", {24'd0, bus.o_data}, {24'd0, e.data});
          check("pulse_cycle", cyc, e.cyc);
        end
      end
      prev_done = bus.o_rx_done;
      prev_err  = bus.o_frame_error;
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    bc    = 0;
    reset = 1'b1;
    bus.i_baud = 1'b0;
    bus.i_rx   = 1'b1;
    hold(1'b1, 4);
    check("reset_o_data", {24'd0, bus.o_data}, 32'd0);
    check("reset_rx_done", {31'd0, bus.o_rx_done}, 32'd0);
    check("reset_frame_error", {31'd0, bus.o_frame_error}, 32'd0);
    reset = 1'b0;
    hold(1'b1, 20);

    // Good frame 0x55.
    send_frame(8'h55, 1'b1, 1'b0, 8'h55);
    hold(1'b1, 40);
    check("after_55", {24'd0, bus.o_data}, 32'h55);

    // Start-bit glitch: low for four baud ticks only.
    align();
    hold(1'b0, 16);
    hold(1'b1, 100);
    check("glitch_keeps_data", {24'd0, bus.o_data}, 32'h55);

    // 0xA3 with a low stop bit, line then held in break.
    send_frame(8'hA3, 1'b0, 1'b1, 8'h55);
    hold(1'b0, 700);
    check("break_keeps_data", {24'd0, bus.o_data}, 32'h55);
    hold(1'b1, 64);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1, 1'b0, 8'h00);
    send_frame(8'hFF, 1'b1, 1'b0, 8'hFF);
    hold(1'b1, 40);
    check("after_ff", {24'd0, bus.o_data}, 32'hFF);

    // Reset in the middle of data bit 3 of 0x81.
    align();
    hold(1'b0, BIT_CLKS);
    hold(1'b1, BIT_CLKS);
    hold(1'b0, BIT_CLKS);
    hold(1'b0, BIT_CLKS);
    hold(1'b0, BIT_CLKS / 2);
    reset = 1'b1;
    hold(1'b1, 2);
    reset = 1'b0;
    check("mid_reset_o_data", {24'd0, bus.o_data}, 32'd0);
    hold(1'b1, 100);
    check("mid_reset_quiet", {24'd0, bus.o_data}, 32'd0);

    send_frame(8'h81, 1'b1, 1'b0, 8'h81);
    hold(1'b1, 100);
    check("after_81", {24'd0, bus.o_data}, 32'h81);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
